muldiv_iter: RTL
================

# muldiv_iter

Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces single-cycle combinational HI/LO arithmetic with an iterative shift-add multiplier and a restoring divider behind a valid/ready handshake. It adds a pipeline-flush abort and defined divide-by-zero and overflow results. The result is held until the pipeline accepts it.

## Interface
- `WIDTH`, default 32: operand width; the product is 2*WIDTH (HI:LO).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `funct`  in  4  operation: 4'b1011 MULT (signed), 4'b1100 MULTU, 4'b1101 DIV (signed), 4'b1110 DIVU; any other value is invalid.
- `a`, `b`  in  WIDTH  multiplicand/dividend, multiplier/divisor.
- `flush`  in  1  synchronous abort of any in-flight or pending operation.
- `out_valid`  out  1  `hi`/`lo` hold a new result.
- `out_ready`  in  1  consumer accepts the result.
- `hi`, `lo`  out  WIDTH each  registered result (product high/low, or remainder/quotient).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: the accept condition is `in_valid && in_ready && !flush`.
  - On accept, latch the operand magnitudes (absolute values for signed ops), the result sign and the remainder sign, and the funct class.
  - Valid funct: go to MUL or DIV with the iteration counter at 0.
  - Invalid funct: the request is consumed, state stays IDLE, and no result is produced.
- MUL: one shift-add step per cycle for WIDTH cycles, forming an unsigned 2*WIDTH product, then go to FIX.
- DIV: one restoring step per cycle for WIDTH cycles, forming the unsigned quotient and remainder, then go to FIX.
- FIX: one cycle that applies signs and special cases, then writes `hi`/`lo` and goes to DONE.
  - MULT: negate the product if the operand signs differ.
  - DIV: the quotient is truncated toward zero and takes sign a^b; the remainder takes the sign of `a`.
  - Divide by zero (DIV or DIVU): `lo` = all ones, `hi` = `a` unmodified.
  - Signed overflow (most-negative / -1): `lo` = most-negative, `hi` = 0. This falls out of the magnitude path and must not be special-cased incorrectly.
- DONE: `out_valid` = 1.
  - `out_valid && out_ready`: go to IDLE.
  - Otherwise hold; `hi`, `lo` and `out_valid` stay stable.
- `flush`: at the next edge, from any state, go to IDLE with `out_valid` = 0. `flush` also blocks an accept in the same cycle. `hi`/`lo` keep their last written value.
- `hi`/`lo` change only on the FIX edge or on reset. After DONE they keep the last result.

## Timing
- Reset (asynchronous assert, any state): state = IDLE, `hi` = `lo` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1, counter = 0.
  - Reset mid-operation discards the operation with no result.
- Let E0 be the accept edge.
  - Iterative path: MUL/DIV run for edges E1..E_WIDTH, FIX is on edge E_WIDTH+1, and `out_valid` rises after E_WIDTH+1. That is WIDTH+1 cycles of latency (33 for WIDTH=32).
  - Fast multiply (see Configuration): MUL lasts one cycle, FIX is on E2, and `out_valid` rises after E2.
- Throughput: the earliest next accept is in the cycle after the result handshake edge; `in_ready` is low throughout DONE.
- `flush` and `out_ready` asserted together in DONE: flush wins; the outcome is the same (IDLE) and no repeat result is produced.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - Defined: MUL computes the full product in a single cycle using a 2*WIDTH combinational multiplier, so multiply latency is 2 cycles.
  - Undefined: MUL iterates WIDTH shift-add steps, so multiply latency is WIDTH+1.
  - Divide behaviour and all results are identical either way.

## Test plan
1. MULT, a=0xFFFFFFFE, b=0x00000003 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. `out_valid` rises 33 cycles after accept without the macro and 2 cycles after with it.
2. MULTU, a=b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. DIVU, a=0x80000000, b=3 -> `lo`=0x2AAAAAAA, `hi`=0x00000002.
3. DIV, a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV, a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
4. DIVU, a=5, b=0 -> `lo`=0xFFFFFFFF, `hi`=5. DIV, a=0xFFFFFFF0, b=0 -> `lo`=0xFFFFFFFF, `hi`=0xFFFFFFF0.
5. Start DIV, pulse `flush` at iteration 10 -> `out_valid` never rises and `in_ready`=1 on the next cycle. A following MULTU 6*7 gives `lo`=42 and `hi`=0.
6. Result held with `out_ready`=0 for 5 cycles -> `out_valid`, `hi` and `lo` stay constant, and an `in_valid` pulse is not accepted. Then assert `resetn`=0 mid-DIV -> all outputs immediately take their reset values.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiplier, restoring divider, HI:LO result.
// Latency: WIDTH+1 cycles accept-to-out_valid (multiply is 2 cycles when MULDIV_FAST_MUL_EN is defined).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid && out_ready.
//
// Ports:
//   clk, resetn            - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      - request handshake; funct selects MULT/MULTU/DIV/DIVU
//   a, b                   - multiplicand/dividend, multiplier/divisor
//   flush                  - synchronous abort of any in-flight or pending operation
//   out_valid/out_ready    - result handshake; hi/lo hold product high/low or remainder/quotient
//   busy                   - high whenever the unit is not IDLE
//
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle combinational multiply).

module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);

   localparam logic [3:0] F_MULT  = 4'b1011;
   localparam logic [3:0] F_MULTU = 4'b1100;
   localparam logic [3:0] F_DIV   = 4'b1101;
   localparam logic [3:0] F_DIVU  = 4'b1110;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   ma_q, ma_d;        // |a| for signed ops, a otherwise
   logic [WIDTH-1:0]   mb_q, mb_d;        // |b| for signed ops, b otherwise
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;  // untouched dividend, returned on divide by zero
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               is_div_q, is_div_d;
   // Shared work register.
   //   multiply: {partial product high, multiplier being shifted out / product low}
   //   divide:   {partial remainder, dividend being shifted out / quotient bits shifted in}
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // ------------------------------------------------------------------
   // Request decode: magnitudes and result signs
   // ------------------------------------------------------------------
   logic             req_signed;
   logic             req_is_mul;
   logic             req_is_div;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;

   always_comb begin
      req_is_mul = (funct == F_MULT) || (funct == F_MULTU);
      req_is_div = (funct == F_DIV)  || (funct == F_DIVU);
      req_signed = (funct == F_MULT) || (funct == F_DIV);
      // The most-negative value negates to itself, which is the correct
      // unsigned magnitude; the divide overflow case relies on this.
      abs_a = (req_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
      abs_b = (req_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
   end

   // ------------------------------------------------------------------
   // One multiply step
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0] mul_next;

`ifdef MULDIV_FAST_MUL_EN
   always_comb begin
      mul_next = {{WIDTH{1'b0}}, ma_q} * {{WIDTH{1'b0}}, mb_q};
   end
`else
   logic [WIDTH-1:0] mul_addend;
   logic [WIDTH:0]   mul_sum;

   always_comb begin
      // LSB of the low half is the current multiplier bit; the carry out of
      // the add becomes the new MSB as the whole register shifts right.
      mul_addend = work_q[0] ? ma_q : '0;
      mul_sum    = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
      mul_next   = {mul_sum, work_q[WIDTH-1:1]};
   end
`endif

   // ------------------------------------------------------------------
   // One restoring divide step
   // ------------------------------------------------------------------
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic               div_qbit;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, mb_q};
      // No borrow means the divisor fits: keep the difference, quotient bit 1.
      div_qbit  = ~div_trial[WIDTH];
      div_rem   = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_next  = {div_rem, work_q[WIDTH-2:0], div_qbit};
   end

   // ------------------------------------------------------------------
   // Sign fix-up and special cases
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               div_by_zero;

   always_comb begin
      prod_fix    = neg_res_q ? (~work_q + 1'b1) : work_q;
      quo_fix     = neg_res_q ? (~work_q[WIDTH-1:0] + 1'b1) : work_q[WIDTH-1:0];
      rem_fix     = neg_rem_q ? (~work_q[2*WIDTH-1:WIDTH] + 1'b1) : work_q[2*WIDTH-1:WIDTH];
      div_by_zero = (mb_q == '0);
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      a_raw_d   = a_raw_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      is_div_d  = is_div_q;
      work_d    = work_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Operands are latched for any funct; an invalid one is simply
               // consumed without leaving IDLE.
               ma_d      = abs_a;
               mb_d      = abs_b;
               a_raw_d   = a;
               neg_res_d = req_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_rem_d = req_signed && a[WIDTH-1];
               is_div_d  = req_is_div;
               cnt_d     = '0;
               if (req_is_mul) begin
                  state_d = S_MUL;
                  work_d  = {{WIDTH{1'b0}}, abs_b};
               end else if (req_is_div) begin
                  state_d = S_DIV;
                  work_d  = {{WIDTH{1'b0}}, abs_a};
               end
            end
         end

         S_MUL: begin
            work_d = mul_next;
`ifdef MULDIV_FAST_MUL_EN
            state_d = S_FIX;
`else
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         S_DIV: begin
            work_d = div_next;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_FIX: begin
            state_d = S_DONE;
            if (!is_div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (div_by_zero) begin
               hi_d = a_raw_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Flush dominates everything: it blocks an accept, aborts iteration,
      // drops a pending result, and suppresses a FIX-edge write.
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ma_q      <= '0;
         mb_q      <= '0;
         a_raw_q   <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
         work_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ma_q      <= ma_d;
         mb_q      <= mb_d;
         a_raw_q   <= a_raw_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         is_div_q  <= is_div_d;
         work_q    <= work_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      out_valid = (state_q == S_DONE);
      hi        = hi_q;
      lo        = lo_q;
   end

endmodule
